// File: rtl/fwd_hazard_unit_pkg.sv
// Shared constants and types for the forwarding / load-use hazard unit.
// Imported by the top level, the per-source select block and the testbench.
package fwd_hazard_unit_pkg;

   localparam logic FWD_SEL_REGFILE = 1'b0;
   localparam logic FWD_SEL_FORWARD = 1'b1;

   // Producer stage indices; a lower index is a younger producer.
   localparam int STG_EX  = 0;
   localparam int STG_MEM = 1;
   localparam int STG_WB  = 2;

   typedef enum logic {
      HZ_RUN   = 1'b0,
      HZ_STALL = 1'b1
   } hz_state_e;

endpackage

// File: rtl/fwd_hazard_unit_src_select.sv
// Per-source forwarding select: the youngest stage with a registered hit supplies
// the operand; with no hit the output is zero and the register file value is used.
module fwd_src_select
   import fwd_hazard_unit_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int NUM_STG = 2
) (
   input  logic [NUM_STG-1:0]      hit,
   input  logic [NUM_STG*XLEN-1:0] rd_stg,
   output logic                    fwd_sel,
   output logic [XLEN-1:0]         fwd_data
);

   always_comb begin
      // NOTE: every output gets a default first so no path through the loop can infer a latch.
      fwd_sel  = FWD_SEL_REGFILE;
      fwd_data = '0;
      // Walk from the oldest stage down so the youngest hit is the last, winning, assignment.
      for (int k = NUM_STG - 1; k >= 0; k--) begin
         if (hit[k]) begin
            fwd_sel  = FWD_SEL_FORWARD;
            fwd_data = rd_stg[k*XLEN +: XLEN];
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: ID-stage source/destination matching,
// ID->EX hit registers, per-source operand forwarding and a load-use stall FSM.
module fwd_hazard_unit
   import fwd_hazard_unit_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int RA_W     = 5,
   parameter int NUM_SRC  = 2,
   parameter int NUM_STG  = 2,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_SRC*RA_W-1:0] rs_id,
   input  logic [NUM_STG*RA_W-1:0] wr_stg,
   input  logic [NUM_STG-1:0]      we_stg,
   input  logic [NUM_STG*XLEN-1:0] rd_stg,
   input  logic                    ld_ex,
   input  logic                    hold_i,
   input  logic                    flush_i,
   output logic [NUM_SRC-1:0]      fwd_sel,
   output logic [NUM_SRC*XLEN-1:0] fwd_data,
   output logic                    stall_o,
   output logic [CNT_W-1:0]        stall_cnt
);

   localparam int LAT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
   localparam logic [LAT_W-1:0] LAT_INIT = (LOAD_LAT > 1) ? LAT_W'(LOAD_LAT - 2) : '0;

   logic [NUM_SRC-1:0][NUM_STG-1:0] match;
   logic [NUM_SRC-1:0][NUM_STG-1:0] hit_d, hit_q;
   logic                            lu;
   hz_state_e                       state_d, state_q;
   logic [LAT_W-1:0]                lat_cnt_d, lat_cnt_q;
   logic [CNT_W-1:0]                stall_cnt_d, stall_cnt_q;

   // Source/destination compare; x0 is never a producer.
   always_comb begin
      match = '0;
      lu    = 1'b0;
      for (int s = 0; s < NUM_SRC; s++) begin
         for (int k = 0; k < NUM_STG; k++) begin
            match[s][k] = we_stg[k] && (wr_stg[k*RA_W +: RA_W] != '0) &&
                          (rs_id[s*RA_W +: RA_W] == wr_stg[k*RA_W +: RA_W]);
         end
         lu = lu | match[s][STG_EX];
      end
      lu = lu & ld_ex;
   end

   always_comb begin
      if (flush_i)     hit_d = '0;
      else if (hold_i) hit_d = hit_q;
      else             hit_d = match;
   end

   // Next-state process of the stall FSM.
   always_comb begin
      state_d   = state_q;
      lat_cnt_d = lat_cnt_q;
      if (flush_i) begin
         state_d   = HZ_RUN;
         lat_cnt_d = '0;
      end else begin
         case (state_q)
            HZ_RUN: begin
               if (lu && (LOAD_LAT > 1)) begin
                  state_d   = HZ_STALL;
                  lat_cnt_d = LAT_INIT;
               end
            end
            HZ_STALL: begin
               if (!hold_i) begin
                  if (lat_cnt_q == '0) state_d   = HZ_RUN;
                  else                 lat_cnt_d = lat_cnt_q - 1'b1;
               end
            end
            default: state_d = HZ_RUN;
         endcase
      end
   end

   // Output process of the stall FSM; reset masks the combinational load-use path.
   always_comb begin
      stall_o = (state_q == HZ_STALL) || (lu && !flush_i && !rst);
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_q       <= '0;
         state_q     <= HZ_RUN;
         lat_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
         hit_q       <= hit_d;
         state_q     <= state_d;
         lat_cnt_q   <= lat_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

   for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      fwd_src_select #(
         .XLEN    (XLEN),
         .NUM_STG (NUM_STG)
      ) u_sel (
         .hit      (hit_q[s]),
         .rd_stg   (rd_stg),
         .fwd_sel  (fwd_sel[s]),
         .fwd_data (fwd_data[s*XLEN +: XLEN])
      );
   end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios plus randomized traffic
// compared against a behavioural model of forwarding and load-use stalling.
module tb_fwd_hazard_unit;
   import fwd_hazard_unit_pkg::*;

   localparam int XLEN     = 32;
   localparam int RA_W     = 5;
   localparam int NUM_SRC  = 2;
   localparam int NUM_STG  = 3;
   localparam int LOAD_LAT = 2;
   localparam int CNT_W    = 4;
   localparam int VW       = CNT_W + 1 + NUM_SRC + NUM_SRC*XLEN;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic [NUM_SRC*RA_W-1:0] rs_id   = '0;
   logic [NUM_STG*RA_W-1:0] wr_stg  = '0;
   logic [NUM_STG-1:0]      we_stg  = '0;
   logic [NUM_STG*XLEN-1:0] rd_stg  = '0;
   logic                    ld_ex   = 1'b0;
   logic                    hold_i  = 1'b0;
   logic                    flush_i = 1'b0;
   logic [NUM_SRC-1:0]      fwd_sel;
   logic [NUM_SRC*XLEN-1:0] fwd_data;
   logic                    stall_o;
   logic [CNT_W-1:0]        stall_cnt;

   fwd_hazard_unit #(
      .XLEN (XLEN), .RA_W (RA_W), .NUM_SRC (NUM_SRC), .NUM_STG (NUM_STG),
      .LOAD_LAT (LOAD_LAT), .CNT_W (CNT_W)
   ) dut (
      .clk (clk), .rst (rst), .rs_id (rs_id), .wr_stg (wr_stg), .we_stg (we_stg),
      .rd_stg (rd_stg), .ld_ex (ld_ex), .hold_i (hold_i), .flush_i (flush_i),
      .fwd_sel (fwd_sel), .fwd_data (fwd_data), .stall_o (stall_o), .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Model state: registered hits, stall cycles still owed after the current one, stall count.
   bit   m_hit [NUM_SRC][NUM_STG];
   int   m_rem;
   int   m_cnt;
   logic exp_stall;
   logic [VW-1:0] exp_vec;
   logic [VW-1:0] got_vec;

   assign got_vec = {stall_cnt, stall_o, fwd_sel, fwd_data};

   function automatic logic [RA_W-1:0] rs(int s);
      return rs_id[s*RA_W +: RA_W];
   endfunction

   function automatic logic [RA_W-1:0] wr(int k);
      return wr_stg[k*RA_W +: RA_W];
   endfunction

   function automatic bit writes(int s, int k);
      return we_stg[k] && wr(k) != 0 && rs(s) == wr(k);
   endfunction

   function automatic bit load_use();
      bit any = 0;
      for (int s = 0; s < NUM_SRC; s++) any |= writes(s, 0);
      return ld_ex && any;
   endfunction

   task automatic model_reset();
      foreach (m_hit[s, k]) m_hit[s][k] = 0;
      m_rem = 0;
      m_cnt = 0;
   endtask

   task automatic model_eval();
      logic [NUM_SRC-1:0]      sel;
      logic [NUM_SRC*XLEN-1:0] data;
      bit found;
      sel  = '0;
      data = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         found = 0;
         for (int k = 0; k < NUM_STG; k++) begin
            if (!found && m_hit[s][k]) begin
               found = 1;
               sel[s] = 1'b1;
               data[s*XLEN +: XLEN] = rd_stg[k*XLEN +: XLEN];
            end
         end
      end
      if (rst)            exp_stall = 1'b0;
      else if (m_rem > 0) exp_stall = 1'b1;
      else                exp_stall = load_use() && !flush_i;
      exp_vec = {CNT_W'(m_cnt), exp_stall, sel, data};
   endtask

   // Advance one clock from just after a negedge; the model consumes the pre-edge inputs.
   task automatic clk_step();
      @(posedge clk);
      if (exp_stall && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      if (flush_i)        m_rem = 0;
      else if (m_rem > 0) begin if (!hold_i) m_rem--; end
      else if (exp_stall) m_rem = LOAD_LAT - 1;
      foreach (m_hit[s, k]) begin
         if (flush_i)      m_hit[s][k] = 0;
         else if (!hold_i) m_hit[s][k] = writes(s, k);
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      rs_id = '0; wr_stg = '0; we_stg = '0; rd_stg = '0;
      ld_ex = 1'b0; hold_i = 1'b0; flush_i = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      #1 model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rs_id = {5'd0, 5'd3}; wr_stg = {10'd0, 5'd3}; we_stg = 3'b001; ld_ex = 1'b1;
      #3;
      n_cmp++;
      if (got_vec !== '0) begin
         n_err++; $display("FAIL reset_async got=%h exp=0", got_vec);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (got_vec !== '0) begin
         n_err++; $display("FAIL reset_clocked got=%h exp=0", got_vec);
      end
      @(negedge clk);
      idle_inputs();
      model_reset();
      rst = 1'b0;
      #1 model_eval();
      n_cmp++;
      if (got_vec !== exp_vec) begin
         n_err++; $display("FAIL reset_release got=%h exp=%h", got_vec, exp_vec);
      end
      clk_step();
   endtask

   task automatic test_ex_fwd();
      rs_id = {5'd5, 5'd2}; wr_stg = {5'd9, 5'd4, 5'd5}; we_stg = 3'b001;
      rd_stg = {32'h1234_5678, 32'hCAFE_0000, 32'hDEAD_BEEF};
      #1 model_eval();
      n_cmp++;
      if (got_vec !== exp_vec) begin
         n_err++; $display("FAIL ex_fwd_pre got=%h exp=%h", got_vec, exp_vec);
      end
      clk_step();
      we_stg = '0; wr_stg = '0;
      #1 model_eval();
      n_cmp++;
      if (fwd_sel !== 2'b10) begin
         n_err++; $display("FAIL ex_fwd_sel got=%b exp=10", fwd_sel);
      end
      n_cmp++;
      if (fwd_data !== {32'hDEAD_BEEF, 32'h0}) begin
         n_err++; $display("FAIL ex_fwd_data got=%h exp=deadbeef00000000", fwd_data);
      end
      n_cmp++;
      if (got_vec !== exp_vec) begin
         n_err++; $display("FAIL ex_fwd_model got=%h exp=%h", got_vec, exp_vec);
      end
      clk_step();
   endtask

   task automatic test_priority_x0();
      rs_id = {5'd9, 5'd7}; wr_stg = {5'd7, 5'd7, 5'd7}; we_stg = 3'b111;
      rd_stg = {32'h33, 32'h22, 32'h11};
      #1 model_eval();
      clk_step();
      #1 model_eval();
      n_cmp++;
      if (fwd_data[XLEN-1:0] !== 32'h11 || fwd_sel !== 2'b01) begin
         n_err++; $display("FAIL prio_ex sel=%b data=%h exp sel=01 data=11", fwd_sel, fwd_data[XLEN-1:0]);
      end
      rs_id = {5'd9, 5'd0}; wr_stg = {5'd0, 5'd0, 5'd0};
      #0 model_eval();
      clk_step();
      #1 model_eval();
      n_cmp++;
      if (fwd_sel[0] !== 1'b0) begin
         n_err++; $display("FAIL x0_no_match got=%b exp=0", fwd_sel[0]);
      end
      n_cmp++;
      if (got_vec !== exp_vec) begin
         n_err++; $display("FAIL x0_model got=%h exp=%h", got_vec, exp_vec);
      end
      clk_step();
   endtask

   task automatic test_load_use();
      logic [2:0] seen;
      do_reset();
      rs_id = {5'd3, 5'd1}; wr_stg = {10'd0, 5'd3}; we_stg = 3'b001; ld_ex = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1 model_eval();
         seen[c] = stall_o;
         n_cmp++;
         if (got_vec !== exp_vec) begin
            n_err++; $display("FAIL load_use_c%0d got=%h exp=%h", c, got_vec, exp_vec);
         end
         clk_step();
         ld_ex = 1'b0; we_stg = '0;
      end
      n_cmp++;
      if (seen !== 3'b011) begin
         n_err++; $display("FAIL load_use_window got=%b exp=011", seen);
      end
      n_cmp++;
      if (stall_cnt !== 4'd2) begin
         n_err++; $display("FAIL load_use_cnt got=%0d exp=2", stall_cnt);
      end
   endtask

   task automatic test_hold_flush();
      logic [NUM_SRC-1:0] sel_at_stall;
      rs_id = {5'd3, 5'd3}; wr_stg = {10'd0, 5'd3}; we_stg = 3'b001; ld_ex = 1'b1;
      rd_stg = {32'h0, 32'h0, 32'hA5A5_0001};
      #1 model_eval();
      clk_step();
      sel_at_stall = fwd_sel;
      ld_ex = 1'b0; we_stg = 3'b111; wr_stg = {5'd8, 5'd8, 5'd8}; hold_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1 model_eval();
         n_cmp++;
         if (stall_o !== 1'b1 || fwd_sel !== sel_at_stall || fwd_sel !== 2'b11) begin
            n_err++; $display("FAIL hold_c%0d stall=%b sel=%b exp stall=1 sel=11", c, stall_o, fwd_sel);
         end
         n_cmp++;
         if (got_vec !== exp_vec) begin
            n_err++; $display("FAIL hold_model_c%0d got=%h exp=%h", c, got_vec, exp_vec);
         end
         clk_step();
      end
      flush_i = 1'b1;
      #1 model_eval();
      n_cmp++;
      if (got_vec !== exp_vec || stall_o !== 1'b1) begin
         n_err++; $display("FAIL flush_cycle got=%h exp=%h", got_vec, exp_vec);
      end
      clk_step();
      idle_inputs();
      #1 model_eval();
      n_cmp++;
      if (fwd_sel !== 2'b00 || stall_o !== 1'b0) begin
         n_err++; $display("FAIL after_flush sel=%b stall=%b exp 00/0", fwd_sel, stall_o);
      end
      clk_step();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         for (int s = 0; s < NUM_SRC; s++) rs_id[s*RA_W +: RA_W] = RA_W'($urandom_range(0, 3));
         for (int k = 0; k < NUM_STG; k++) begin
            wr_stg[k*RA_W +: RA_W] = RA_W'($urandom_range(0, 3));
            rd_stg[k*XLEN +: XLEN] = $urandom;
         end
         we_stg  = NUM_STG'($urandom);
         ld_ex   = ($urandom_range(0, 9) < 3);
         hold_i  = ($urandom_range(0, 9) < 2);
         flush_i = ($urandom_range(0, 9) < 1);
         #1 model_eval();
         n_cmp++;
         if (got_vec !== exp_vec) begin
            n_err++; $display("FAIL random_c%0d got=%h exp=%h", c, got_vec, exp_vec);
         end
         clk_step();
      end
      idle_inputs();
   endtask

   task automatic test_saturation();
      do_reset();
      rs_id = {5'd6, 5'd0}; wr_stg = {10'd0, 5'd6}; we_stg = 3'b001; ld_ex = 1'b1;
      for (int c = 0; c < 20; c++) begin
         #1 model_eval();
         n_cmp++;
         if (got_vec !== exp_vec) begin
            n_err++; $display("FAIL sat_c%0d got=%h exp=%h", c, got_vec, exp_vec);
         end
         clk_step();
      end
      n_cmp++;
      if (stall_cnt !== 4'hF || stall_o !== 1'b1) begin
         n_err++; $display("FAIL sat_value cnt=%h stall=%b exp F/1", stall_cnt, stall_o);
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (stall_o !== 1'b0 || stall_cnt !== '0 || fwd_sel !== '0) begin
         n_err++; $display("FAIL async_rst stall=%b cnt=%h sel=%b exp 0/0/0", stall_o, stall_cnt, fwd_sel);
      end
      model_reset();
      @(negedge clk);
      idle_inputs();
      rst = 1'b0;
      #1 model_eval();
      n_cmp++;
      if (got_vec !== exp_vec) begin
         n_err++; $display("FAIL post_rst got=%h exp=%h", got_vec, exp_vec);
      end
      clk_step();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_ex_fwd();
      test_priority_x0();
      test_load_use();
      test_hold_flush();
      test_random();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
